ccw_parser: RTL and testbench

CCW_PARSER -- requirements
Module: ccw_parser

---
 rtl/ccw_parser_pkg.sv | 16 +
 rtl/ccw_parser_if.sv | 22 ++
 rtl/ccw_parser_gap_timer.sv | 30 +++
 rtl/ccw_parser.sv | 150 +++++++++++++++
 tb/tb_ccw_parser.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/ccw_parser_pkg.sv
// Message definitions shared by the CCW transmit and receive sides.
// Holds the framing byte values and the abort cause encoding reported
// on err_code.
package ccw_parser_pkg;

  localparam logic [7:0] MARKER_MASTER             = 8'hA5;
  localparam logic [7:0] FLAG_CONTROL_COMMAND_WORD = 8'h3C;

  typedef enum logic [1:0] {
    ERR_BAD_FLAG = 2'd0,
    ERR_BAD_LEN  = 2'd1,
    ERR_TIMEOUT  = 2'd2,
    ERR_DECODER  = 2'd3
  } err_code_e;

endpackage

// File: rtl/ccw_parser_if.sv
// Byte stream from the line decoder into the parser, and the parsed
// payload/status stream out of it.
//   master : line decoder side (drives d, d_rdy, dec_err; observes outputs)
//   slave  : parser side (consumes bytes; drives q, q_vld, msg_start,
//            msg_end, err, err_code, busy)
interface ccw_parser_if;
  logic [7:0] d;
  logic       d_rdy;
  logic       dec_err;
  logic [7:0] q;
  logic       q_vld;
  logic       msg_start;
  logic       msg_end;
  logic       err;
  logic [1:0] err_code;
  logic       busy;

  modport master (output d, d_rdy, dec_err,
                  input  q, q_vld, msg_start, msg_end, err, err_code, busy);
  modport slave  (input  d, d_rdy, dec_err,
                  output q, q_vld, msg_start, msg_end, err, err_code, busy);
endinterface

// File: rtl/ccw_parser_gap_timer.sv
// Inter-byte gap timer.
//   clr     : a byte arrived this cycle, restart the gap
//   en      : a message is in progress, count idle cycles
//   expired : this cycle is the TIMEOUT_CYC-th idle cycle since the last byte
// clr dominates, so a byte landing on the expiry cycle is never a timeout.
module ccw_parser_gap_timer #(
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic clk,
  input  logic n_rst,
  input  logic clr,
  input  logic en,
  output logic expired
);
  localparam int CW = $clog2(TIMEOUT_CYC + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign expired = en && !clr && (cnt_q == CW'(TIMEOUT_CYC - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr || !en || expired) cnt_d = '0;
    else                       cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) cnt_q <= '0;
    else        cnt_q <= cnt_d;
endmodule

// File: rtl/ccw_parser.sv
// CCW message parser: hunts for MARKER, checks FLAG, reads a 16-bit
// big-endian length, then forwards the payload bytes one cycle after
// they arrive. Aborts (err pulse + held err_code) on bad flag, bad
// length, inter-byte timeout or a decoder error mid-message.
//   clk, n_rst : clock, async active-low reset
//   bus        : slave side of ccw_parser_if
// All outputs come straight from flops.
module ccw_parser
  import ccw_parser_pkg::*;
#(
  parameter int TIMEOUT_CYC = 1024,
  parameter int MAX_LEN     = 255
) (
  input  logic          clk,
  input  logic          n_rst,
  ccw_parser_if.slave   bus
);
  typedef enum logic [2:0] {HUNT, FLAG, N1, N2, PAYLOAD} state_e;

  localparam logic [15:0] MAX_LEN16 = 16'(MAX_LEN);

  state_e     state_q, state_d;
  logic [7:0] len_hi_q, len_hi_d;
  logic [15:0] cnt_q, cnt_d;
  logic       first_q, first_d;
  logic [7:0] q_q, q_d;
  logic       q_vld_q, q_vld_d;
  logic       start_q, start_d;
  logic       end_q, end_d;
  logic       err_q, err_d;
  err_code_e  code_q, code_d;
  logic       busy_q, busy_d;

  logic        in_msg;
  logic        tmo;
  logic [15:0] len_w;

  assign in_msg = (state_q != HUNT);
  assign len_w  = {len_hi_q, bus.d};

  ccw_parser_gap_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_gap_timer (
    .clk     (clk),
    .n_rst   (n_rst),
    .clr     (bus.d_rdy),
    .en      (in_msg),
    .expired (tmo)
  );

  always_comb begin
    state_d  = state_q;
    len_hi_d = len_hi_q;
    cnt_d    = cnt_q;
    first_d  = first_q;
    q_d      = q_q;
    q_vld_d  = 1'b0;
    start_d  = 1'b0;
    end_d    = 1'b0;
    err_d    = 1'b0;
    code_d   = code_q;

    // Decoder error outranks the byte in the same cycle; the byte
    // outranks a coincident timeout.
    if (in_msg && bus.dec_err) begin
      err_d   = 1'b1;
      code_d  = ERR_DECODER;
      state_d = HUNT;
    end else if (bus.d_rdy) begin
      unique case (state_q)
        HUNT: if (bus.d == MARKER_MASTER) state_d = FLAG;
        FLAG: begin
          if (bus.d == FLAG_CONTROL_COMMAND_WORD) state_d = N1;
          else begin
            err_d   = 1'b1;
            code_d  = ERR_BAD_FLAG;
            state_d = HUNT;
          end
        end
        N1: begin
          len_hi_d = bus.d;
          state_d  = N2;
        end
        N2: begin
          if (len_w == 16'd0 || len_w > MAX_LEN16) begin
            err_d   = 1'b1;
            code_d  = ERR_BAD_LEN;
            state_d = HUNT;
          end else begin
            cnt_d   = len_w;
            first_d = 1'b1;
            state_d = PAYLOAD;
          end
        end
        PAYLOAD: begin
          q_d     = bus.d;
          q_vld_d = 1'b1;
          start_d = first_q;
          first_d = 1'b0;
          cnt_d   = cnt_q - 16'd1;
          if (cnt_q == 16'd1) begin
            end_d   = 1'b1;
            state_d = HUNT;
          end
        end
        default: state_d = HUNT;
      endcase
    end else if (tmo) begin
      err_d   = 1'b1;
      code_d  = ERR_TIMEOUT;
      state_d = HUNT;
    end

    if (state_d == HUNT) cnt_d = 16'd0;
    busy_d = (state_d != HUNT);
  end

  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) begin
      state_q  <= HUNT;
      len_hi_q <= '0;
      cnt_q    <= '0;
      first_q  <= 1'b0;
      q_q      <= '0;
      q_vld_q  <= 1'b0;
      start_q  <= 1'b0;
      end_q    <= 1'b0;
      err_q    <= 1'b0;
      code_q   <= ERR_BAD_FLAG;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      len_hi_q <= len_hi_d;
      cnt_q    <= cnt_d;
      first_q  <= first_d;
      q_q      <= q_d;
      q_vld_q  <= q_vld_d;
      start_q  <= start_d;
      end_q    <= end_d;
      err_q    <= err_d;
      code_q   <= code_d;
      busy_q   <= busy_d;
    end

  assign bus.q         = q_q;
  assign bus.q_vld     = q_vld_q;
  assign bus.msg_start = start_q;
  assign bus.msg_end   = end_q;
  assign bus.err       = err_q;
  assign bus.err_code  = code_q;
  assign bus.busy      = busy_q;
endmodule

// File: tb/tb_ccw_parser.sv
// Directed bench for ccw_parser: a per-cycle vector table for the
// framing/length/decoder-error cases, plus hand sequences for timeout,
// byte-vs-timeout race and mid-message reset.
module tb_ccw_parser;
  import ccw_parser_pkg::*;

  localparam int T = 16;
  localparam logic [7:0] M = 8'hA5;
  localparam logic [7:0] F = 8'h3C;

  logic clk = 1'b0;
  logic n_rst = 1'b0;
  always #5 clk = ~clk;

  ccw_parser_if bus ();

  ccw_parser #(.TIMEOUT_CYC(T), .MAX_LEN(255)) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  // obs = {q_vld, q, msg_start, msg_end, err, err_code, busy}
  typedef struct packed {
    logic        rdy;
    logic        de;
    logic [7:0]  d;
    logic [14:0] exp;
  } vec_t;

  vec_t tbl[$];
  int total = 0;
  int bad   = 0;

  function automatic logic [14:0] obs();
    return {bus.q_vld, bus.q, bus.msg_start, bus.msg_end, bus.err, bus.err_code, bus.busy};
  endfunction

  function automatic logic [14:0] mk(input logic vld, input logic [7:0] qq, input logic st,
                                     input logic en, input logic er, input logic [1:0] cd,
                                     input logic bs);
    return {vld, qq, st, en, er, cd, bs};
  endfunction

  task automatic chk(input string nm, input logic [14:0] act, input logic [14:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got vld=%b q=%h st=%b end=%b err=%b code=%0d busy=%b, want vld=%b q=%h st=%b end=%b err=%b code=%0d busy=%b",
               nm, act[14], act[13:6], act[5], act[4], act[3], act[2:1], act[0],
               exp[14], exp[13:6], exp[5], exp[4], exp[3], exp[2:1], exp[0]);
    end
  endtask

  task automatic add(input logic rdy, input logic de, input logic [7:0] dd, input logic [14:0] e);
    tbl.push_back('{rdy, de, dd, e});
  endtask

  task automatic drive(input logic rdy, input logic de, input logic [7:0] b);
    @(negedge clk);
    bus.d = b; bus.d_rdy = rdy; bus.dec_err = de;
    @(posedge clk);
    #1;
    bus.d_rdy = 1'b0; bus.dec_err = 1'b0;
  endtask

  task automatic send(input logic [7:0] b);
    drive(1'b1, 1'b0, b);
  endtask

  // Idle until err shows up; checks it lands on exactly the T-th idle cycle
  // and that nothing is delivered meanwhile.
  task automatic wait_timeout(input string nm);
    bit seen = 0;
    for (int n = 1; n <= 3 * T && !seen; n++) begin
      drive(1'b0, 1'b0, 8'h00);
      if (bus.q_vld || bus.msg_end) chk({nm, "_quiet"}, obs(), 15'h0);
      if (bus.err) begin
        seen = 1;
        total++;
        if (n != T) begin
          bad++;
          $display("FAIL %s_cycle: err after %0d idle cycles, want %0d", nm, n, T);
        end
        chk({nm, "_err"}, {6'h0, bus.err, bus.err_code, bus.busy}, {6'h0, 1'b1, 2'd2, 1'b0});
      end
    end
    if (!seen) begin
      total++; bad++;
      $display("FAIL %s_bound: no err within %0d cycles, want err at %0d", nm, 3 * T, T);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, want completion");
    $fatal(1);
  end

  initial begin
    bus.d = 8'h00; bus.d_rdy = 1'b0; bus.dec_err = 1'b0;

    // three-byte message
    add(1,0,M,     mk(0,8'h00,0,0,0,0,1));
    add(1,0,F,     mk(0,8'h00,0,0,0,0,1));
    add(1,0,8'h00, mk(0,8'h00,0,0,0,0,1));
    add(1,0,8'h03, mk(0,8'h00,0,0,0,0,1));
    add(1,0,8'hA1, mk(1,8'hA1,1,0,0,0,1));
    add(1,0,8'hB2, mk(1,8'hB2,0,0,0,0,1));
    add(1,0,8'hC3, mk(1,8'hC3,0,1,0,0,0));
    // junk in HUNT, then len 1
    add(1,0,8'h55, mk(0,8'hC3,0,0,0,0,0));
    add(1,0,8'h00, mk(0,8'hC3,0,0,0,0,0));
    add(1,0,M,     mk(0,8'hC3,0,0,0,0,1));
    add(1,0,F,     mk(0,8'hC3,0,0,0,0,1));
    add(1,0,8'h00, mk(0,8'hC3,0,0,0,0,1));
    add(1,0,8'h01, mk(0,8'hC3,0,0,0,0,1));
    add(1,0,8'h7E, mk(1,8'h7E,1,1,0,0,0));
    // back-to-back marker, bad flag, then a good message
    add(1,0,M,     mk(0,8'h7E,0,0,0,0,1));
    add(1,0,8'h99, mk(0,8'h7E,0,0,1,0,0));
    add(1,0,M,     mk(0,8'h7E,0,0,0,0,1));
    add(1,0,F,     mk(0,8'h7E,0,0,0,0,1));
    add(1,0,8'h00, mk(0,8'h7E,0,0,0,0,1));
    add(1,0,8'h02, mk(0,8'h7E,0,0,0,0,1));
    add(1,0,8'h11, mk(1,8'h11,1,0,0,0,1));
    add(1,0,8'h22, mk(1,8'h22,0,1,0,0,0));
    // length 256 and length 0
    add(1,0,M,     mk(0,8'h22,0,0,0,0,1));
    add(1,0,F,     mk(0,8'h22,0,0,0,0,1));
    add(1,0,8'h01, mk(0,8'h22,0,0,0,0,1));
    add(1,0,8'h00, mk(0,8'h22,0,0,1,1,0));
    add(1,0,M,     mk(0,8'h22,0,0,0,1,1));
    add(1,0,F,     mk(0,8'h22,0,0,0,1,1));
    add(1,0,8'h00, mk(0,8'h22,0,0,0,1,1));
    add(1,0,8'h00, mk(0,8'h22,0,0,1,1,0));
    // length 255 accepted; decoder error mid-payload discards its byte
    add(1,0,M,     mk(0,8'h22,0,0,0,1,1));
    add(1,0,F,     mk(0,8'h22,0,0,0,1,1));
    add(1,0,8'h00, mk(0,8'h22,0,0,0,1,1));
    add(1,0,8'hFF, mk(0,8'h22,0,0,0,1,1));
    add(1,0,8'h11, mk(1,8'h11,1,0,0,1,1));
    add(1,1,8'hFF, mk(0,8'h11,0,0,1,3,0));
    // decoder error in HUNT ignored
    add(0,1,8'h00, mk(0,8'h11,0,0,0,3,0));
    add(0,0,8'h00, mk(0,8'h11,0,0,0,3,0));

    #1;
    chk("reset_async", obs(), 15'h0);
    @(negedge clk); n_rst = 1'b1;
    @(posedge clk); #1;
    chk("reset_release", obs(), 15'h0);

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].rdy, tbl[i].de, tbl[i].d);
      chk($sformatf("vec%0d", i), obs(), tbl[i].exp);
    end

    // timeout after one delivered byte, no msg_end
    send(M); send(F); send(8'h00); send(8'h04); send(8'h11);
    chk("tmo_first", obs(), mk(1,8'h11,1,0,0,3,1));
    wait_timeout("tmo");

    // byte on the expiry cycle wins, gap restarts from it
    send(M); send(F); send(8'h00); send(8'h04); send(8'h11);
    for (int n = 0; n < T - 1; n++) drive(1'b0, 1'b0, 8'h00);
    send(8'h22);
    chk("race_byte_wins", obs(), mk(1,8'h22,0,0,0,2,1));
    wait_timeout("tmo2");

    // async reset mid-payload, then a clean message
    send(M); send(F); send(8'h00); send(8'h03); send(8'h11);
    @(negedge clk); n_rst = 1'b0;
    #1;
    chk("rst_mid_async", obs(), 15'h0);
    @(posedge clk); #1;
    chk("rst_mid_hold", obs(), 15'h0);
    @(negedge clk); n_rst = 1'b1;
    drive(1'b0, 1'b0, 8'h00);
    chk("rst_mid_release", obs(), 15'h0);
    send(M); send(F); send(8'h00); send(8'h01); send(8'h5A);
    chk("post_rst_msg", obs(), mk(1,8'h5A,1,1,0,0,0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
